// File: rtl/decoder_seq.sv
`default_nettype none
// ============================================================================
// Module      : decoder_seq
// Description : Registered, parametrised binary-to-one-hot decoder
//               (SEL_W -> 2**SEL_W) with a valid/ready input handshake,
//               enable gating and an optional auto-scan mode that walks
//               every output with a programmable dwell time.
//               The auto-scan mode is compiled in only when the macro
//               DEC_SCAN_EN is defined; without it the block is a plain
//               registered decoder with IDLE/HOLD states only.
// Ports       : clk        - rising-edge clock
//               rst_n      - asynchronous active-low reset
//               en         - block enable, 0 forces outputs inactive
//               in_valid   - in_sel valid
//               in_ready   - input may be accepted this cycle
//               in_sel     - binary select
//               scan_start - start auto-scan (DEC_SCAN_EN only)
//               scan_stop  - abort auto-scan (DEC_SCAN_EN only)
//               dwell      - hold time minus one per scan output
//               out        - registered one-hot (one-cold if ACTIVE_LOW)
//               out_valid  - out holds a decoded value
//               busy       - auto-scan in progress
//               scan_done  - single-cycle pulse at scan completion
// Revision    : 1.0 - initial release
// ============================================================================
module decoder_seq #(
    parameter int SEL_W      = 3,
    parameter int DWELL_W    = 8,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SEL_W-1:0]      in_sel,
    input  logic                  scan_start,
    input  logic                  scan_stop,
    input  logic [DWELL_W-1:0]    dwell,
    output logic [(1<<SEL_W)-1:0] out,
    output logic                  out_valid,
    output logic                  busy,
    output logic                  scan_done
);

    localparam int OUT_W = 1 << SEL_W;

    localparam logic [OUT_W-1:0] c_one  = {{(OUT_W-1){1'b0}}, 1'b1};

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_hold = 2'd1;
`ifdef DEC_SCAN_EN
    localparam logic [1:0] c_scan = 2'd2;

    localparam logic [SEL_W-1:0] c_last_idx = {SEL_W{1'b1}};
`endif

    logic [1:0]       r_state;
    // Internal value is always active-high; polarity is applied at the port.
    logic [OUT_W-1:0] r_onehot;
    logic             r_out_valid;

`ifdef DEC_SCAN_EN
    logic [SEL_W-1:0]   r_idx;
    logic [DWELL_W-1:0] r_cnt;
    logic [DWELL_W-1:0] r_dwell;
    logic               r_scan_done;
    logic               w_busy;

    assign w_busy    = (r_state == c_scan);
    // scan_start blocks the input so a coincident in_valid is never accepted.
    assign in_ready  = en & ~w_busy & ~scan_start;
    assign busy      = w_busy;
    assign scan_done = r_scan_done;
`else
    // Scan controls have no function in this build.
    logic w_unused_scan;

    assign w_unused_scan = ^{scan_start, scan_stop, dwell};
    assign in_ready      = en;
    assign busy          = 1'b0;
    assign scan_done     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_idle;
            r_onehot    <= '0;
            r_out_valid <= 1'b0;
`ifdef DEC_SCAN_EN
            r_idx       <= '0;
            r_cnt       <= '0;
            r_dwell     <= '0;
            r_scan_done <= 1'b0;
`endif
        end else begin
`ifdef DEC_SCAN_EN
            r_scan_done <= 1'b0;
`endif
            if (!en) begin
                // Disable aborts everything, including a running scan,
                // without a completion pulse.
                r_state     <= c_idle;
                r_onehot    <= '0;
                r_out_valid <= 1'b0;
            end
`ifdef DEC_SCAN_EN
            else if (r_state == c_scan) begin
                if (scan_stop) begin
                    r_state     <= c_idle;
                    r_onehot    <= '0;
                    r_out_valid <= 1'b0;
                end else if (r_cnt == r_dwell) begin
                    if (r_idx == c_last_idx) begin
                        // Last output finished its dwell: end without wrap.
                        r_state     <= c_idle;
                        r_onehot    <= '0;
                        r_out_valid <= 1'b0;
                        r_scan_done <= 1'b1;
                    end else begin
                        r_idx    <= r_idx + 1'b1;
                        r_cnt    <= '0;
                        r_onehot <= r_onehot << 1;
                    end
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else if (scan_start) begin
                // Takes priority over in_valid and a coincident scan_stop.
                r_dwell     <= dwell;
                r_idx       <= '0;
                r_cnt       <= '0;
                r_onehot    <= c_one;
                r_out_valid <= 1'b1;
                r_state     <= c_scan;
            end
`endif
            else if (in_valid) begin
                r_onehot    <= c_one << in_sel;
                r_out_valid <= 1'b1;
                r_state     <= c_hold;
            end
        end
    end

    assign out_valid = r_out_valid;

    generate
        if (ACTIVE_LOW) begin : g_active_low
            assign out = ~r_onehot;
        end else begin : g_active_high
            assign out = r_onehot;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_decoder_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_decoder_seq
// Description : Directed self-checking bench for decoder_seq. Drives a
//               default 3-to-8 instance and an ACTIVE_LOW 4-to-16 instance
//               from shared control signals.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decoder_seq;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       in_valid;
    logic [2:0] in_sel;
    logic [3:0] in_sel_al;
    logic       scan_start;
    logic       scan_stop;
    logic [7:0] dwell;

    logic       in_ready;
    logic [7:0] out;
    logic       out_valid;
    logic       busy;
    logic       scan_done;

    logic        in_ready_al;
    logic [15:0] out_al;
    logic        out_valid_al;
    logic        busy_al;
    logic        scan_done_al;

    int errors = 0;
    int checks = 0;

    decoder_seq #(.SEL_W(3), .DWELL_W(8), .ACTIVE_LOW(1'b0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .scan_start(scan_start),
        .scan_stop (scan_stop),
        .dwell     (dwell),
        .out       (out),
        .out_valid (out_valid),
        .busy      (busy),
        .scan_done (scan_done)
    );

    decoder_seq #(.SEL_W(4), .DWELL_W(8), .ACTIVE_LOW(1'b1)) dut_al (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_valid  (in_valid),
        .in_ready  (in_ready_al),
        .in_sel    (in_sel_al),
        .scan_start(scan_start),
        .scan_stop (scan_stop),
        .dwell     (dwell),
        .out       (out_al),
        .out_valid (out_valid_al),
        .busy      (busy_al),
        .scan_done (scan_done_al)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
            $error("check %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_out;

    initial begin
        rst_n      = 1'b0;
        en         = 1'b0;
        in_valid   = 1'b0;
        in_sel     = 3'd0;
        in_sel_al  = 4'd0;
        scan_start = 1'b0;
        scan_stop  = 1'b0;
        dwell      = 8'd0;
        #2;

        // Reset state
        check("rst_out",       32'(out),          32'h00);
        check("rst_out_valid", 32'(out_valid),    32'h0);
        check("rst_busy",      32'(busy),         32'h0);
        check("rst_scan_done", 32'(scan_done),    32'h0);
        check("rst_in_ready",  32'(in_ready),     32'h0);
        check("rst_out_al",    32'(out_al),       32'hFFFF);
        check("rst_valid_al",  32'(out_valid_al), 32'h0);

        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("idle_out", 32'(out), 32'h00);

        // Test 1: back-to-back accepts of every select, one-cycle lag
        en = 1'b1;
        #1;
        check("in_ready_en", 32'(in_ready), 32'h1);
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_sel = 3'(i);
            tick();
            exp_out = 8'h01 << i;
            check("seq_out",   32'(out),       32'(exp_out));
            check("seq_valid", 32'(out_valid), 32'h1);
        end

        // Test 6 (active-low instance rides along): accept in_sel=9
        in_sel    = 3'd5;
        in_sel_al = 4'd9;
        tick();
        in_valid = 1'b0;
        check("al_out",   32'(out_al),       32'hFDFF);
        check("al_valid", 32'(out_valid_al), 32'h1);

        // Test 2: select 5 held for 20 idle cycles
        check("hold_first", 32'(out), 32'h20);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("hold_out", 32'(out), 32'h20);
        end
        check("hold_valid", 32'(out_valid), 32'h1);
        check("al_hold",    32'(out_al),    32'hFDFF);

        en = 1'b0;
        #1;
        check("dis_in_ready", 32'(in_ready), 32'h0);
        tick();
        check("dis_out",    32'(out),       32'h00);
        check("dis_valid",  32'(out_valid), 32'h0);
        check("dis_out_al", 32'(out_al),    32'hFFFF);

        // in_valid while disabled must not be taken
        in_valid = 1'b1;
        in_sel   = 3'd3;
        tick();
        check("dis_noaccept", 32'(out), 32'h00);
        in_valid = 1'b0;
        en       = 1'b1;
        tick();

        // Test 4: scan_start together with in_valid, in_sel=6
        dwell      = 8'd0;
        scan_start = 1'b1;
        in_valid   = 1'b1;
        in_sel     = 3'd6;
        #1;
`ifdef DEC_SCAN_EN
        check("race_in_ready", 32'(in_ready), 32'h0);
        tick();
        scan_start = 1'b0;
        in_valid   = 1'b0;
        check("race_out",  32'(out),  32'h01);
        check("race_busy", 32'(busy), 32'h1);

        // Test 5: dwell=0 advances every cycle; stop at idx=3
        tick();
        check("adv_idx1", 32'(out), 32'h02);
        scan_start = 1'b1;           // ignored while scanning
        tick();
        scan_start = 1'b0;
        check("adv_idx2", 32'(out), 32'h04);
        tick();
        check("adv_idx3", 32'(out), 32'h08);
        scan_stop = 1'b1;
        tick();
        scan_stop = 1'b0;
        check("stop_out",  32'(out),       32'h00);
        check("stop_busy", 32'(busy),      32'h0);
        check("stop_done", 32'(scan_done), 32'h0);
        check("stop_vld",  32'(out_valid), 32'h0);

        // Test 3: full scan, dwell=2 -> every output for 3 cycles
        dwell      = 8'd2;
        scan_start = 1'b1;
        scan_stop  = 1'b1;           // ignored outside SCAN
        tick();
        scan_start = 1'b0;
        scan_stop  = 1'b0;
        dwell      = 8'd9;           // latched value must be used
        for (int idx = 0; idx < 8; idx++) begin
            for (int c = 0; c < 3; c++) begin
                exp_out = 8'h01 << idx;
                check("scan_out",  32'(out),       32'(exp_out));
                check("scan_done_lo", 32'(scan_done), 32'h0);
                tick();
            end
        end
        check("end_done",  32'(scan_done), 32'h1);
        check("end_out",   32'(out),       32'h00);
        check("end_busy",  32'(busy),      32'h0);
        check("end_valid", 32'(out_valid), 32'h0);
        tick();
        check("end_done_pulse", 32'(scan_done), 32'h0);
        check("end_no_wrap",    32'(out),       32'h00);

        // Asynchronous reset in the middle of a scan
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        tick();
        check("pre_rst_busy", 32'(busy), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out",  32'(out),       32'h00);
        check("arst_busy", 32'(busy),      32'h0);
        check("arst_done", 32'(scan_done), 32'h0);
        check("arst_vld",  32'(out_valid), 32'h0);
`else
        // Scan controls ignored: input accepted normally
        check("race_in_ready", 32'(in_ready), 32'h1);
        tick();
        scan_start = 1'b0;
        in_valid   = 1'b0;
        check("race_out",  32'(out),       32'h40);
        check("race_busy", 32'(busy),      32'h0);
        scan_stop = 1'b1;
        tick();
        scan_stop = 1'b0;
        check("stop_ign_out", 32'(out),       32'h40);
        check("stop_ign_done", 32'(scan_done), 32'h0);

        // Asynchronous reset while holding a value
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out",    32'(out),       32'h00);
        check("arst_vld",    32'(out_valid), 32'h0);
        check("arst_out_al", 32'(out_al),    32'hFFFF);
`endif
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_out", 32'(out), 32'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
